rd_arb_sched: RTL and testbench
===============================

RD_ARB_SCHED -- requirements
Module: rd_arb_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of read requesters sharing one FIFO read port, 2..8.
REQ-002 SHALL have parameter DSIZE, default 8: FIFO data width.
REQ-003 SHALL have parameter BURST_LEN, default 4: maximum consecutive reads per grant when bursting is compiled in, 1..15.
REQ-004 SHALL have port rclk, input, 1: single clock; all state on its rising edge.
REQ-005 SHALL have port rrst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port req, input, NREQ: per-requester read request, level-sensitive.
REQ-007 SHALL have port rempty, input, 1: FIFO empty flag, registered, from the read-pointer block.
REQ-008 SHALL have port rdata, input, DSIZE: FIFO read data at the current read address, valid combinationally.
REQ-009 SHALL have port rinc, output, 1: FIFO read-increment strobe.
REQ-010 SHALL have port gnt, output, NREQ: one-hot current-cycle grant, combinational.
REQ-011 SHALL have port dout, output, DSIZE: registered read data.
REQ-012 SHALL have port dvalid, output, NREQ: one-hot registered data-valid, qualifies dout for its requester.

Function
REQ-013 gnt SHALL be all-zero when rempty=1, req=0 or rrst=1; otherwise exactly one bit SHALL be set.
REQ-014 The winner SHALL be the first set req bit at or after round-robin pointer rr_ptr, scanning upward modulo NREQ.
REQ-015 rinc SHALL equal OR of gnt; no read SHALL ever be issued when rempty=1.
REQ-016 On any cycle with rinc=1: dout SHALL load rdata and dvalid SHALL load gnt at the next edge; latency is exactly 1 cycle.
REQ-017 On any cycle with rinc=0, dvalid SHALL be 0 at the next edge and dout SHALL hold its value.
REQ-018 After a grant ends, rr_ptr SHALL become winner index + 1, wrapping NREQ-1 to 0; rr_ptr SHALL hold on cycles with no grant.
REQ-019 A requester dropping req SHALL lose the grant the same cycle, with no read issued for it.
REQ-020 rr_ptr SHALL be ceil(log2 NREQ) bits; the wrap SHALL be explicit compare-to-NREQ-1, not natural overflow.

Reset
REQ-021 While rrst=1 at a rising edge: rr_ptr=0, dout=0, dvalid=0, burst counter=0, state=IDLE.
REQ-022 While rrst=1, rinc and gnt SHALL be 0 combinationally; reset asserted mid-burst SHALL abandon the burst with no read issued.

Configuration
REQ-023 Macro RD_ARB_BURST_EN SHALL compile in burst locking; absent, every grant lasts one read and rr_ptr advances after every read.
REQ-024 With RD_ARB_BURST_EN, the FSM SHALL have states IDLE and BURST; IDLE->BURST on a read with BURST_LEN>1, counter loaded to 1.
REQ-025 In BURST, the locked requester SHALL keep the grant while req=1, rempty=0 and counter<BURST_LEN; the counter SHALL increment per read.
REQ-026 BURST->IDLE SHALL occur when the counter reaches BURST_LEN, the locked req drops, or rempty=1; rr_ptr SHALL advance past the locked requester on that exit.

Verification
REQ-027 SHALL test: reset, req=4'b1111, rempty=0, macro off -> gnt 0001,0010,0100,1000,0001 on consecutive cycles; dvalid follows one cycle later.
REQ-028 SHALL test: req=4'b1010, rr_ptr=2 -> first gnt=1000; next gnt=0010 (pointer wrap).
REQ-029 SHALL test: rempty rises with req=4'b1111 -> rinc=0, gnt=0 the same cycle; rr_ptr unchanged; the sequence resumes at the same index when rempty falls.
REQ-030 SHALL test: macro on, BURST_LEN=4, req=4'b0011, FIFO holds 10 words -> 4 reads for req0, 4 for req1, then 2 for req0; each dout matches FIFO order.
REQ-031 SHALL test: macro on, req0 drops after 2 burst reads -> grant moves to req1 the same cycle; the FSM returns to IDLE.
REQ-032 SHALL test: rrst pulsed mid-burst -> rinc=0 during reset; dvalid=0, dout=0 and rr_ptr=0 after the edge.

Source files
------------

// File: rtl/rd_arb_sched.sv
// Round-robin read arbiter for a shared FIFO read port, with registered data return.
// Define RD_ARB_BURST_EN to lock a winner for up to BURST_LEN consecutive reads.
module rd_arb_sched #(
   parameter int NREQ      = 4,
   parameter int DSIZE     = 8,
   parameter int BURST_LEN = 4
) (
   input  logic             rclk,
   input  logic             rrst,
   input  logic [NREQ-1:0]  req,
   input  logic             rempty,
   input  logic [DSIZE-1:0] rdata,
   output logic             rinc,
   output logic [NREQ-1:0]  gnt,
   output logic [DSIZE-1:0] dout,
   output logic [NREQ-1:0]  dvalid
);

   localparam int PW = $clog2(NREQ);
   localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] rr_ptr_nxt;
   logic [PW-1:0] win_idx;
   logic [PW-1:0] sel;
   logic [PW:0]   idx;
   logic          win_vld;
   logic          grant;

`ifdef RD_ARB_BURST_EN
   typedef enum logic {IDLE, BURST} state_t;
   localparam logic [3:0] BLEN = 4'(BURST_LEN);

   state_t        state;
   state_t        state_nxt;
   logic [PW-1:0] lock;
   logic [PW-1:0] lock_nxt;
   logic [3:0]    cnt;
   logic [3:0]    cnt_nxt;
   logic          hold;
`endif

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + PW'(1);
   endfunction

   // first requester at or after rr_ptr; descending offsets so the nearest wins
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      idx     = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = {1'b0, rr_ptr} + (PW+1)'(k);
         if (idx >= (PW+1)'(NREQ))
            idx = idx - (PW+1)'(NREQ);
         if (req[idx[PW-1:0]]) begin
            win_vld = 1'b1;
            win_idx = idx[PW-1:0];
         end
      end
   end

   // grant selection, pointer advance and burst next-state
   always_comb begin
      grant      = 1'b0;
      sel        = win_idx;
      rr_ptr_nxt = rr_ptr;
`ifdef RD_ARB_BURST_EN
      state_nxt = state;
      lock_nxt  = lock;
      cnt_nxt   = cnt;
      hold      = (state == BURST) && req[lock] && !rempty && (cnt < BLEN);
`endif
      if (!rrst && !rempty) begin
`ifdef RD_ARB_BURST_EN
         if (hold) begin
            grant   = 1'b1;
            sel     = lock;
            cnt_nxt = cnt + 4'd1;
            if (cnt + 4'd1 == BLEN) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         end else if (win_vld) begin
            grant      = 1'b1;
            rr_ptr_nxt = wrap_inc(win_idx);
            if (BLEN > 4'd1) begin
               state_nxt = BURST;
               lock_nxt  = win_idx;
               cnt_nxt   = 4'd1;
            end else begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         end
`else
         if (win_vld) begin
            grant      = 1'b1;
            rr_ptr_nxt = wrap_inc(win_idx);
         end
`endif
      end
`ifdef RD_ARB_BURST_EN
      // no read this cycle: any burst in progress is over
      if (!grant) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end
`endif
      gnt  = grant ? (NREQ'(1) << sel) : '0;
      rinc = grant;
   end

   // state registers; read data captured one cycle after the strobe
   always_ff @(posedge rclk) begin
      if (rrst) begin
         rr_ptr <= '0;
         dout   <= '0;
         dvalid <= '0;
`ifdef RD_ARB_BURST_EN
         state  <= IDLE;
         lock   <= '0;
         cnt    <= '0;
`endif
      end else begin
         rr_ptr <= rr_ptr_nxt;
         dvalid <= gnt;
         if (rinc)
            dout <= rdata;
`ifdef RD_ARB_BURST_EN
         state  <= state_nxt;
         lock   <= lock_nxt;
         cnt    <= cnt_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_rd_arb_sched.sv
// Bench for rd_arb_sched: vector table, burst/reset sequences, random vs model.
// Honours RD_ARB_BURST_EN the same way as the design.
module tb_rd_arb_sched;

   localparam int NREQ = 4;
   localparam int DSIZE = 8;
   localparam int BL = 4;

   logic             rclk = 1'b0;
   logic             rrst = 1'b1;
   logic [NREQ-1:0]  req = '0;
   logic             rempty = 1'b1;
   logic [DSIZE-1:0] rdata = '0;
   logic             rinc;
   logic [NREQ-1:0]  gnt;
   logic [DSIZE-1:0] dout;
   logic [NREQ-1:0]  dvalid;

   int n_vec = 0;
   int n_mis = 0;

   rd_arb_sched #(.NREQ(NREQ), .DSIZE(DSIZE), .BURST_LEN(BL)) dut (
      .rclk(rclk), .rrst(rrst), .req(req), .rempty(rempty),
      .rdata(rdata), .rinc(rinc), .gnt(gnt), .dout(dout), .dvalid(dvalid)
   );

   always #5 rclk = ~rclk;

   typedef struct {
      logic       rst;
      logic [3:0] rq;
      logic       e;
      logic [7:0] d;
      logic [3:0] xg;
      logic [3:0] xv;
      logic [7:0] xd;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // one cycle: drive, check combinational grant, then registered return
   task automatic step(input logic r, input logic [3:0] q, input logic e,
                       input logic [7:0] d, input logic [3:0] xg,
                       input logic [3:0] xv, input logic [7:0] xd,
                       input string nm);
      @(negedge rclk);
      rrst = r;
      req = q;
      rempty = e;
      rdata = d;
      #1;
      chk({nm, ".gnt"}, 32'(gnt), 32'(xg));
      chk({nm, ".rinc"}, 32'(rinc), 32'(|xg));
      @(posedge rclk);
      #1;
      chk({nm, ".dvalid"}, 32'(dvalid), 32'(xv));
      chk({nm, ".dout"}, 32'(dout), 32'(xd));
   endtask

   function automatic int first_from(input logic [3:0] q, input int p);
      for (int k = 0; k < NREQ; k++)
         if (q[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   initial begin
      vec_t tbl[15];
      int ord[10];
      int m_ptr, m_lock, m_cnt, w;
      logic cont;
      logic [7:0] m_dout;
      logic [3:0] m_dv, xg, q;
      logic r, e;
      logic [7:0] d;

      // all four requesting: strict rotation, stall on empty, wrap, drop
      tbl[0]  = '{1'b1, 4'b1111, 1'b0, 8'hAA, 4'b0000, 4'b0000, 8'h00};
      tbl[1]  = '{1'b0, 4'b1111, 1'b0, 8'h11, 4'b0001, 4'b0001, 8'h11};
      tbl[2]  = '{1'b0, 4'b1111, 1'b0, 8'h12, 4'b0010, 4'b0010, 8'h12};
      tbl[3]  = '{1'b0, 4'b1111, 1'b0, 8'h13, 4'b0100, 4'b0100, 8'h13};
      tbl[4]  = '{1'b0, 4'b1111, 1'b0, 8'h14, 4'b1000, 4'b1000, 8'h14};
      tbl[5]  = '{1'b0, 4'b1111, 1'b0, 8'h15, 4'b0001, 4'b0001, 8'h15};
      tbl[6]  = '{1'b0, 4'b1111, 1'b1, 8'h16, 4'b0000, 4'b0000, 8'h15};
      tbl[7]  = '{1'b0, 4'b1111, 1'b1, 8'h17, 4'b0000, 4'b0000, 8'h15};
      tbl[8]  = '{1'b0, 4'b1111, 1'b0, 8'h18, 4'b0010, 4'b0010, 8'h18};
      tbl[9]  = '{1'b0, 4'b1010, 1'b0, 8'h19, 4'b1000, 4'b1000, 8'h19};
      tbl[10] = '{1'b0, 4'b1010, 1'b0, 8'h1A, 4'b0010, 4'b0010, 8'h1A};
      tbl[11] = '{1'b0, 4'b0000, 1'b0, 8'h1B, 4'b0000, 4'b0000, 8'h1A};
      tbl[12] = '{1'b1, 4'b1111, 1'b0, 8'h1C, 4'b0000, 4'b0000, 8'h00};
      tbl[13] = '{1'b0, 4'b0100, 1'b0, 8'h1D, 4'b0100, 4'b0100, 8'h1D};
      tbl[14] = '{1'b0, 4'b0011, 1'b0, 8'h1E, 4'b0001, 4'b0001, 8'h1E};

      ord = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};

`ifndef RD_ARB_BURST_EN
      for (int i = 0; i < 15; i++)
         step(tbl[i].rst, tbl[i].rq, tbl[i].e, tbl[i].d,
              tbl[i].xg, tbl[i].xv, tbl[i].xd, $sformatf("vec%0d", i));
`else
      // ten queued words, two requesters: 4 + 4 + 2 reads in FIFO order
      step(1'b1, 4'b0011, 1'b0, 8'h00, 4'b0, 4'b0, 8'h00, "brst_rst");
      for (int i = 0; i < 10; i++)
         step(1'b0, 4'b0011, 1'b0, 8'(8'hA0 + i), 4'(1 << ord[i]),
              4'(1 << ord[i]), 8'(8'hA0 + i), $sformatf("burst%0d", i));
      step(1'b0, 4'b0011, 1'b1, 8'hFF, 4'b0, 4'b0, 8'hA9, "burst_empty");

      // locked requester drops: grant moves on in the same cycle
      step(1'b1, 4'b0000, 1'b0, 8'h00, 4'b0, 4'b0, 8'h00, "drop_rst");
      step(1'b0, 4'b0001, 1'b0, 8'hB0, 4'b0001, 4'b0001, 8'hB0, "drop0");
      step(1'b0, 4'b0001, 1'b0, 8'hB1, 4'b0001, 4'b0001, 8'hB1, "drop1");
      step(1'b0, 4'b0010, 1'b0, 8'hB2, 4'b0010, 4'b0010, 8'hB2, "drop2");
      step(1'b0, 4'b0011, 1'b0, 8'hB3, 4'b0010, 4'b0010, 8'hB3, "drop3");
      step(1'b0, 4'b0001, 1'b0, 8'hB4, 4'b0001, 4'b0001, 8'hB4, "drop4");
`endif

      // reset in the middle of a grant run
      step(1'b1, 4'b0000, 1'b0, 8'h00, 4'b0, 4'b0, 8'h00, "mid_rst0");
      step(1'b0, 4'b1111, 1'b0, 8'hC0, 4'b0001, 4'b0001, 8'hC0, "mid_a");
`ifdef RD_ARB_BURST_EN
      step(1'b0, 4'b1111, 1'b0, 8'hC1, 4'b0001, 4'b0001, 8'hC1, "mid_b");
`else
      step(1'b0, 4'b1111, 1'b0, 8'hC1, 4'b0010, 4'b0010, 8'hC1, "mid_b");
`endif
      step(1'b1, 4'b1111, 1'b0, 8'hC2, 4'b0000, 4'b0000, 8'h00, "mid_rst");
      step(1'b0, 4'b1111, 1'b0, 8'hC3, 4'b0001, 4'b0001, 8'hC3, "mid_after");

      // random traffic against the reference model
      step(1'b1, 4'b0000, 1'b1, 8'h00, 4'b0, 4'b0, 8'h00, "rnd_rst");
      m_ptr = 0;
      m_lock = -1;
      m_cnt = 0;
      m_dout = '0;
      m_dv = '0;
      for (int i = 0; i < 400; i++) begin
         r = ($urandom_range(0, 31) == 0);
         e = ($urandom_range(0, 3) == 0);
         q = 4'($urandom);
         d = 8'($urandom);
         w = -1;
         cont = 1'b0;
         if (!r && !e) begin
`ifdef RD_ARB_BURST_EN
            if (m_lock >= 0 && q[m_lock] && m_cnt < BL) begin
               w = m_lock;
               cont = 1'b1;
            end else
`endif
               w = first_from(q, m_ptr);
         end
         xg = (w >= 0) ? 4'(1 << w) : 4'b0;
         if (r) begin
            m_ptr = 0;
            m_lock = -1;
            m_cnt = 0;
            m_dout = '0;
            m_dv = '0;
         end else if (w >= 0) begin
            m_dout = d;
            m_dv = xg;
            if (cont) begin
               m_cnt++;
               if (m_cnt == BL) begin
                  m_lock = -1;
                  m_cnt = 0;
               end
            end else begin
               m_ptr = (w + 1) % NREQ;
`ifdef RD_ARB_BURST_EN
               if (BL > 1) begin
                  m_lock = w;
                  m_cnt = 1;
               end
`endif
            end
         end else begin
            m_dv = '0;
            m_lock = -1;
            m_cnt = 0;
         end
         step(r, q, e, d, xg, m_dv, m_dout, $sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
